// File: rtl/tl_pkg.sv
// TileLink D-channel types shared by the D-channel arbiter and its picker.
package tl_pkg;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2,
        Grant         = 3'd4,
        GrantData     = 3'd5,
        ReleaseAck    = 3'd6
    } tl_d_op_e;

    typedef struct packed {
        tl_d_op_e    opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [7:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } tl_d_t;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    function automatic logic d_has_data(input tl_d_op_e op);
        return (op == AccessAckData) || (op == GrantData);
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, searching cyclically.
module tl_rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/tl_burst_arbiter_d.sv
// N-to-1 TileLink D-channel arbiter: round-robin between messages, locked for a whole burst.
// Define TL_ARB_D_PRIO_EN to add prio_i, which restricts the idle search to prioritised sources.
module tl_burst_arbiter_d
    import tl_pkg::*;
#(
    parameter int unsigned  N_SRC      = 2,
    parameter type          DATA_T     = tl_d_t,
    parameter int unsigned  BEAT_BYTES = 8,
    parameter int unsigned  MAX_SIZE   = 6,
    localparam int unsigned IdxW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  DATA_T            inp_bits_i [N_SRC],
    input  logic [N_SRC-1:0] inp_valid_i,
`ifdef TL_ARB_D_PRIO_EN
    input  logic [N_SRC-1:0] prio_i,
`endif
    output logic [N_SRC-1:0] inp_ready_o,
    output DATA_T            oup_bits_o,
    output logic             oup_valid_o,
    input  logic             oup_ready_i,
    output logic             oup_first_o,
    output logic             oup_last_o,
    output logic [IdxW-1:0]  grant_idx_o,
    output logic             busy_o
);

    localparam int unsigned BeatLog = $clog2(BEAT_BYTES);
    localparam int unsigned MaxLog  = (MAX_SIZE > BeatLog) ? MAX_SIZE - BeatLog : 0;
    localparam int unsigned CntW    = MaxLog + 1;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] hold_idx_q, hold_idx_d;
    logic            hold_q, hold_d;
    logic [CntW-1:0] beats_left_q, beats_left_d;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] pick_gnt;
    logic [IdxW-1:0]  pick_idx;
    logic [IdxW-1:0]  grant_idx;
    logic [N_SRC-1:0] grant_oh;
    logic [CntW-1:0]  beats;
    int unsigned      size_eff;
    logic             hs;

`ifdef TL_ARB_D_PRIO_EN
    assign req = (|(inp_valid_i & prio_i)) ? (inp_valid_i & prio_i) : inp_valid_i;
`else
    assign req = inp_valid_i;
`endif

    tl_rr_pick #(
        .N    (N_SRC),
        .IdxW (IdxW)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Oversized transfers clamp to MAX_SIZE so the counter can never overflow.
    always_comb begin
        size_eff = 32'(oup_bits_o.size);
        if (size_eff > MAX_SIZE) begin
            size_eff = MAX_SIZE;
        end
        beats = CntW'(1);
        if (d_has_data(oup_bits_o.opcode) && (size_eff > BeatLog)) begin
            beats = CntW'(1) << (size_eff - BeatLog);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            hold_idx_q   <= '0;
            hold_q       <= 1'b0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            hold_idx_q   <= hold_idx_d;
            hold_q       <= hold_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign hs = oup_valid_o & oup_ready_i;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_idx_d   = lock_idx_q;
        hold_idx_d   = hold_idx_q;
        hold_d       = hold_q;
        beats_left_d = beats_left_q;
        unique case (state_q)
            StIdle: begin
                // A presented but unaccepted winner keeps the grant until it is taken.
                hold_d     = oup_valid_o & ~oup_ready_i;
                hold_idx_d = grant_idx;
                if (hs) begin
                    rr_ptr_d = (grant_idx == IdxW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
                    if (beats > CntW'(1)) begin
                        lock_idx_d   = grant_idx;
                        beats_left_d = beats - 1'b1;
                        state_d      = StBurst;
                    end
                end
            end
            StBurst: begin
                hold_d = 1'b0;
                if (hs) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_idx = pick_idx;
        grant_oh  = pick_gnt;
        if (state_q == StBurst) begin
            grant_idx = lock_idx_q;
        end else if (hold_q) begin
            grant_idx = hold_idx_q;
        end
        if ((state_q == StBurst) || hold_q) begin
            grant_oh            = '0;
            grant_oh[grant_idx] = 1'b1;
        end
        oup_bits_o  = inp_bits_i[grant_idx];
        oup_valid_o = rst_i & inp_valid_i[grant_idx];
        inp_ready_o = {N_SRC{oup_ready_i & rst_i}} & inp_valid_i & grant_oh;
        oup_first_o = (state_q == StIdle);
        oup_last_o  = (state_q == StIdle) ? (beats == CntW'(1)) : (beats_left_q == CntW'(1));
        busy_o      = (state_q == StBurst);
        grant_idx_o = grant_idx;
    end

    // Sizes beyond MAX_SIZE are clamped above but are still a protocol error upstream.
    assert property (@(posedge clk_i) disable iff (!rst_i)
                     oup_valid_o |-> (32'(oup_bits_o.size) <= MAX_SIZE));

endmodule

// File: tb/tb_tl_burst_arbiter_d.sv
// Scoreboard bench for tl_burst_arbiter_d with three sources and default beat geometry.
module tb_tl_burst_arbiter_d;
    import tl_pkg::*;

    typedef struct packed {
        logic [1:0] idx;
        tl_d_t      bits;
        logic       first;
        logic       last;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    tl_d_t      inp_bits [3];
    logic [2:0] inp_valid;
    logic [2:0] inp_ready;
    tl_d_t      oup_bits;
    logic       oup_valid;
    logic       oup_ready;
    logic       oup_first;
    logic       oup_last;
    logic [1:0] grant_idx;
    logic       busy;

    tl_d_t      src_q [3][$];
    exp_t       sb[$];
    logic [2:0] gate;
    logic [2:0] hs;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       obs_valid, obs_busy, obs_first;
    logic [2:0] obs_ready;
    logic [1:0] obs_grant;
    tl_d_t      obs_bits;

    always #5 clk_i = ~clk_i;

    tl_burst_arbiter_d #(
        .N_SRC      (3),
        .BEAT_BYTES (8),
        .MAX_SIZE   (6)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inp_bits_i  (inp_bits),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .oup_bits_o  (oup_bits),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_first_o (oup_first),
        .oup_last_o  (oup_last),
        .grant_idx_o (grant_idx),
        .busy_o      (busy)
    );

    function automatic tl_d_t mk(input tl_d_op_e op, input logic [3:0] sz, input logic [7:0] src,
                                 input logic [63:0] data);
        tl_d_t d = '0;
        d.opcode = op;
        d.size   = sz;
        d.source = src;
        d.data   = data;
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            inp_valid[i] = !gate[i] && (src_q[i].size() > 0);
            inp_bits[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    // Queue nb beats on source s and record the beats the output must show, in order.
    task automatic push_msg(input int s, input tl_d_op_e op, input logic [3:0] sz, input int nb,
                            input logic [7:0] tag);
        for (int b = 0; b < nb; b++) begin
            tl_d_t d;
            exp_t  e;
            d = mk(op, sz, 8'(s), {tag, 48'h0, 8'(b)});
            src_q[s].push_back(d);
            e.idx   = 2'(s);
            e.bits  = d;
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    // One clock: sample at negedge, score any output beat, retire accepted source beats.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        hs        = inp_ready;
        obs_valid = oup_valid;
        obs_ready = inp_ready;
        obs_busy  = busy;
        obs_first = oup_first;
        obs_grant = grant_idx;
        obs_bits  = oup_bits;
        if (rst_i && oup_valid && oup_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got src %0d data %h, required no beat",
                         grant_idx, oup_bits.data);
            end else begin
                e = sb.pop_front();
                if ({grant_idx, oup_bits, oup_first, oup_last} !==
                    {e.idx, e.bits, e.first, e.last}) begin
                    n_bad++;
                    $display("FAIL beat_order: got src %0d data %h first %b last %b, required src %0d data %h first %b last %b",
                             grant_idx, oup_bits.data, oup_first, oup_last,
                             e.idx, e.bits.data, e.first, e.last);
                end
            end
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (hs[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) src_q[i].delete();
        sb.delete();
        gate = '0;
        drive();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        rst_i = 1'b0;
        for (int s = 0; s < 3; s++) push_msg(s, AccessAck, 4'd2, 1, 8'h10 + 8'(s));
        drive();
        #1;
        n_cmp++;
        if (oup_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b, required 0", oup_valid);
        end
        n_cmp++;
        if (inp_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b, required 000", inp_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({oup_valid, grant_idx} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_first_grant: got valid %b grant %0d, required valid 1 grant 0",
                     oup_valid, grant_idx);
        end
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_burst();
        int busy_cnt = 0;
        push_msg(0, AccessAckData, 4'd6, 8, 8'h20);
        push_msg(1, AccessAck, 4'd2, 1, 8'h21);
        drive();
        repeat (9) begin
            tick();
            if (obs_busy) busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt != 7) begin
            n_bad++;
            $display("FAIL burst_busy_cycles: got %0d, required 7", busy_cnt);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL burst_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int rdy_cnt [3] = '{0, 0, 0};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) push_msg(s, AccessAck, 4'd3, 1, 8'h30 + 8'(r * 3 + s));
        end
        drive();
        repeat (6) begin
            tick();
            n_cmp++;
            if ($countones(obs_ready) != 1) begin
                n_bad++;
                $display("FAIL rr_ready_onehot: got %b, required exactly one bit", obs_ready);
            end
            for (int s = 0; s < 3; s++) rdy_cnt[s] += int'(obs_ready[s]);
        end
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (rdy_cnt[s] != 2) begin
                n_bad++;
                $display("FAIL rr_ready_count src%0d: got %0d, required 2", s, rdy_cnt[s]);
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rr_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_bubble();
        do_reset();
        push_msg(1, AccessAckData, 4'd5, 4, 8'h40);
        drive();
        tick();
        push_msg(0, AccessAck, 4'd2, 1, 8'h41);
        drive();
        tick();
        gate[1] = 1'b1;
        drive();
        repeat (3) begin
            tick();
            n_cmp++;
            if ({obs_valid, obs_ready, obs_busy} !== 5'b0_000_1) begin
                n_bad++;
                $display("FAIL bubble_hold: got valid %b ready %b busy %b, required valid 0 ready 000 busy 1",
                         obs_valid, obs_ready, obs_busy);
            end
        end
        gate[1] = 1'b0;
        drive();
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL bubble_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_stall();
        tl_d_t ref_bits;
        do_reset();
        oup_ready = 1'b0;
        push_msg(0, AccessAck, 4'd3, 1, 8'h50);
        push_msg(1, AccessAckData, 4'd3, 1, 8'h51);
        ref_bits = src_q[0][0];
        drive();
        repeat (4) begin
            tick();
            n_cmp++;
            if ({obs_grant, obs_bits, obs_ready} !== {2'd0, ref_bits, 3'b000}) begin
                n_bad++;
                $display("FAIL stall_hold: got grant %0d data %h ready %b, required grant 0 data %h ready 000",
                         obs_grant, obs_bits.data, obs_ready, ref_bits.data);
            end
        end
        oup_ready = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL stall_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        push_msg(0, AccessAckData, 4'd6, 8, 8'h60);
        drive();
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_busy_before: got %b, required 1", busy);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_busy_async: got %b, required 0", busy);
        end
        n_cmp++;
        if (sb.size() != 6) begin
            n_bad++;
            $display("FAIL midrst_beats_taken: got %0d pending, required 6", sb.size());
        end
        sb.delete();
        src_q[0].delete();
        drive();
        tick();
        rst_i = 1'b1;
        push_msg(1, AccessAck, 4'd2, 1, 8'h61);
        drive();
        tick();
        n_cmp++;
        if ({obs_valid, obs_grant, obs_first, obs_busy} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_regrant: got valid %b grant %0d first %b busy %b, required valid 1 grant 1 first 1 busy 0",
                     obs_valid, obs_grant, obs_first, obs_busy);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        gate      = '0;
        hs        = '0;
        oup_ready = 1'b1;
        drive();
        test_reset();
        test_burst();
        test_round_robin();
        test_bubble();
        test_stall();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
